// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain GPIO event controller.
// Holds the OBI subordinate types, register offsets and the event mode encoding.
package user_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [0:0]  rid;
  } sbr_obi_rsp_t;

  localparam logic [11:0] OffCtrl     = 12'h000;
  localparam logic [11:0] OffEn       = 12'h004;
  localparam logic [11:0] OffMode     = 12'h008;
  localparam logic [11:0] OffPend     = 12'h00C;
  localparam logic [11:0] OffIrqEn    = 12'h010;
  localparam logic [11:0] OffDebounce = 12'h014;
  localparam logic [11:0] OffCount    = 12'h018;
  localparam logic [11:0] OffLimit    = 12'h01C;

  localparam logic [31:0] ErrRdata = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    Rise  = 2'b00,
    Fall  = 2'b01,
    Both  = 2'b10,
    Level = 2'b11
  } gpio_evt_mode_e;

  function automatic logic [31:0] be_mask(logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/user_gpio_debounce.sv
// Single-channel debounce filter: accepts an input change once it has been
// seen for thresh_i+1 consecutive samples.
module user_gpio_debounce #(
  parameter int unsigned DebounceWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DebounceWidth-1:0] thresh_i,
  input  logic                     in_i,
  output logic                     filt_o,
  output logic                     accept_o
);

  logic                     filt_q, filt_d;
  logic [DebounceWidth-1:0] cnt_q, cnt_d;

  // Threshold is compared live, so lowering it mid-count can accept at once.
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = '0;
    accept_o = 1'b0;
    if (in_i != filt_q) begin
      if (cnt_q >= thresh_i) begin
        accept_o = 1'b1;
        filt_d   = in_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/user_gpio_event_ctrl.sv
// Multi-channel GPIO event/interrupt controller with an OBI register port.
// Debounced inputs feed edge/level detection, W1C pending bits, an event counter and irq_o.
module user_gpio_event_ctrl
  import user_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg        = SbrObiCfg,
  parameter type         obi_req_t     = sbr_obi_req_t,
  parameter type         obi_rsp_t     = sbr_obi_rsp_t,
  parameter int unsigned NumChannels   = 16,
  parameter int unsigned DebounceWidth = 16,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t               obi_req_i,
  output obi_rsp_t               obi_rsp_o,
  input  logic [NumChannels-1:0] gpio_i,
  output logic                   irq_o
);

  localparam int unsigned ModeWidth = 2 * NumChannels;

  logic                     ctrl_q, ctrl_d;
  logic [NumChannels-1:0]   en_q, en_d;
  logic [ModeWidth-1:0]     mode_q, mode_d;
  logic [NumChannels-1:0]   pend_q, pend_d;
  logic [NumChannels-1:0]   irqen_q, irqen_d;
  logic [DebounceWidth-1:0] deb_q, deb_d;
  logic [CntWidth-1:0]      count_q, count_d;

  logic                     rvalid_q;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [ObiCfg.IdWidth-1:0] rid_q;

  logic [NumChannels-1:0] filt, accept, evt;

  logic [11:0] off, off_w;
  logic        acc, bad, wr;
  logic [31:0] wmask, cur_w, new_w, w1c_w;
  logic        unused_bits;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    user_gpio_debounce #(
      .DebounceWidth(DebounceWidth)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .thresh_i(deb_q),
      .in_i    (gpio_i[i]),
      .filt_o  (filt[i]),
      .accept_o(accept[i])
    );
  end

  // Level mode looks at the value filt takes on this edge, so pending sets
  // in the same edge for every mode.
  always_comb begin
    evt = '0;
    for (int i = 0; i < NumChannels; i++) begin
      logic new_filt;
      logic det;
      new_filt = filt[i] ^ accept[i];
      unique case (gpio_evt_mode_e'(mode_q[2*i +: 2]))
        Rise:  det = accept[i] & new_filt;
        Fall:  det = accept[i] & ~new_filt;
        Both:  det = accept[i];
        Level: det = new_filt;
      endcase
      evt[i] = det & ctrl_q & en_q[i];
    end
  end

  assign off   = obi_req_i.addr[11:0];
  assign off_w = {off[11:2], 2'b00};
  assign acc   = obi_req_i.req;
  assign bad   = off >= OffLimit;
  assign wr    = acc & obi_req_i.we & ~bad;
  assign wmask = be_mask(obi_req_i.be);
  assign new_w = (cur_w & ~wmask) | (obi_req_i.wdata & wmask);
  assign w1c_w = obi_req_i.wdata & wmask;

  always_comb begin
    case (off_w)
      OffCtrl:     cur_w = 32'(ctrl_q);
      OffEn:       cur_w = 32'(en_q);
      OffMode:     cur_w = 32'(mode_q);
      OffPend:     cur_w = 32'(pend_q);
      OffIrqEn:    cur_w = 32'(irqen_q);
      OffDebounce: cur_w = 32'(deb_q);
      OffCount:    cur_w = 32'(count_q);
      default:     cur_w = '0;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    en_d    = en_q;
    mode_d  = mode_q;
    irqen_d = irqen_q;
    deb_d   = deb_q;
    pend_d  = pend_q;
    count_d = count_q;
    if (wr) begin
      case (off_w)
        OffCtrl:     ctrl_d  = new_w[0];
        OffEn:       en_d    = new_w[NumChannels-1:0];
        OffMode:     mode_d  = new_w[ModeWidth-1:0];
        OffPend:     pend_d  = pend_q & ~w1c_w[NumChannels-1:0];
        OffIrqEn:    irqen_d = new_w[NumChannels-1:0];
        OffDebounce: deb_d   = new_w[DebounceWidth-1:0];
        default:     ;
      endcase
    end
    // Hardware set is applied last so it beats a same-cycle W1C.
    pend_d = pend_d | evt;
    if (wr && off_w == OffCount) begin
      count_d = '0;
    end else if (|evt && count_q != {CntWidth{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (acc) begin
      if (bad) begin
        rdata_d = ErrRdata;
        err_d   = 1'b1;
      end else if (!obi_req_i.we) begin
        rdata_d = cur_w;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= 1'b0;
      en_q     <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      irqen_q  <= '0;
      deb_q    <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      irqen_q  <= irqen_d;
      deb_q    <= deb_d;
      count_q  <= count_d;
      rvalid_q <= acc;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (acc) rid_q <= obi_req_i.aid;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = 1'b1;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

  assign irq_o = ctrl_q & |(pend_q & irqen_q);

  assign unused_bits = ^{obi_req_i.addr[31:12], obi_req_i.addr[1:0], new_w, w1c_w};

endmodule

// File: tb/tb_user_gpio_event_ctrl.sv
// Randomised bench for user_gpio_event_ctrl against a behavioural model of
// the register map, debounce rule, event rules and OBI response timing.
module tb_user_gpio_event_ctrl;
  import user_pkg::*;

  localparam int unsigned NC     = 12;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 4;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  sbr_obi_req_t  req;
  sbr_obi_rsp_t  rsp;
  logic [NC-1:0] gpio;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit          m_filt [NC];
  int          m_run  [NC];
  int          m_mode [NC];
  bit          m_ctrl;
  logic [31:0] m_en, m_pend, m_irqen;
  int          m_deb, m_count;
  bit          exp_rvalid, exp_err;
  logic [31:0] exp_rdata;
  logic        exp_rid;

  user_gpio_event_ctrl #(
    .NumChannels  (NC),
    .DebounceWidth(DW),
    .CntWidth     (CW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(req),
    .obi_rsp_o(rsp),
    .gpio_i   (gpio),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mode_img();
    logic [31:0] v = '0;
    for (int i = 0; i < NC; i++) v = v | (32'(m_mode[i]) << (2 * i));
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] off);
    case (off)
      12'h000: return {31'b0, m_ctrl};
      12'h004: return m_en;
      12'h008: return mode_img();
      12'h00C: return m_pend;
      12'h010: return m_irqen;
      12'h014: return 32'(m_deb);
      12'h018: return 32'(m_count);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      m_filt[i] = 1'b0;
      m_run[i]  = 0;
      m_mode[i] = 0;
    end
    m_ctrl = 0; m_en = '0; m_pend = '0; m_irqen = '0; m_deb = 0; m_count = 0;
    exp_rvalid = 0; exp_err = 0; exp_rdata = '0; exp_rid = 1'b0;
  endtask

  task automatic check_outputs();
    check("irq", 32'(irq), 32'(m_ctrl & |(m_pend & m_irqen)));
    check("gnt", 32'(rsp.gnt), 32'd1);
    check("rvalid", 32'(rsp.rvalid), 32'(exp_rvalid));
    if (exp_rvalid) begin
      check("rdata", rsp.rdata, exp_rdata);
      check("err", 32'(rsp.err), 32'(exp_err));
      check("rid", 32'(rsp.rid), 32'(exp_rid));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_clear();
    @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(rsp.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then check.
  task automatic step(input logic [NC-1:0] g, input bit rq, input bit we,
                      input logic [11:0] off, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] mask, img, clr;
    logic [NC-1:0] set;
    bit bad, cnt_clr, accepted, fire;
    gpio      = g;
    req       = '0;
    req.req   = rq;
    req.addr  = {20'h0, off};
    req.we    = we;
    req.be    = be;
    req.wdata = wd;
    req.aid   = 1'($urandom);

    bad        = off >= 12'h01C;
    exp_rvalid = rq;
    exp_err    = rq && bad;
    exp_rid    = rq ? req.aid : exp_rid;
    exp_rdata  = !rq ? 32'h0 : bad ? 32'hBADCAB1E : we ? 32'h0 : model_read(off);

    // Filter accepts once D+1 consecutive samples disagree with it.
    set = '0;
    for (int ch = 0; ch < NC; ch++) begin
      accepted = 0;
      if (g[ch] != m_filt[ch]) begin
        m_run[ch]++;
        if (m_run[ch] > m_deb) begin
          accepted   = 1;
          m_filt[ch] = g[ch];
          m_run[ch]  = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
      case (m_mode[ch])
        0:       fire = accepted && m_filt[ch];
        1:       fire = accepted && !m_filt[ch];
        2:       fire = accepted;
        default: fire = m_filt[ch];
      endcase
      set[ch] = fire && m_ctrl && m_en[ch];
    end

    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
    clr     = '0;
    cnt_clr = 0;
    if (rq && we && !bad) begin
      img = (model_read(off) & ~mask) | (wd & mask);
      case (off)
        12'h000: m_ctrl  = img[0];
        12'h004: m_en    = img & ((32'd1 << NC) - 1);
        12'h008: for (int i = 0; i < NC; i++) m_mode[i] = int'((img >> (2 * i)) & 32'd3);
        12'h00C: clr     = wd & mask;
        12'h010: m_irqen = img & ((32'd1 << NC) - 1);
        12'h014: m_deb   = int'(img & ((32'd1 << DW) - 1));
        default: cnt_clr = 1;
      endcase
    end
    m_pend = (m_pend & ~clr) | 32'(set);
    if (cnt_clr) m_count = 0;
    else if (set != '0) m_count = (m_count + 1 > CntMax) ? CntMax : m_count + 1;

    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [NC-1:0] g;
    bit rq, we;
    logic [11:0] off;
    logic [3:0] be;
    logic [31:0] wd;
    gpio = '0;
    req  = '0;
    @(negedge clk);
    do_reset();

    for (int r = 0; r < 7; r++) step('0, 1, 0, 12'(r * 4), 4'hF, 32'h0);

    // D=0, ch0 rising, everything enabled.
    step('0, 1, 1, OffDebounce, 4'hF, 32'h0);
    step('0, 1, 1, OffMode, 4'hF, 32'h0);
    step('0, 1, 1, OffEn, 4'hF, 32'h1);
    step('0, 1, 1, OffIrqEn, 4'hF, 32'h1);
    step('0, 1, 1, OffCtrl, 4'hF, 32'h1);
    step(12'h001, 0, 0, 12'h0, 4'h0, 32'h0);
    check("d0_irq", 32'(irq), 32'd1);
    step(12'h001, 1, 0, OffPend, 4'hF, 32'h0);
    check("d0_pend", rsp.rdata, 32'h1);
    step(12'h001, 1, 0, OffCount, 4'hF, 32'h0);
    check("d0_count", rsp.rdata, 32'h1);

    // D=3: a 3-sample pulse is rejected, a 4-sample one accepted.
    step(12'h001, 1, 1, OffEn, 4'hF, 32'h3);
    step(12'h001, 1, 1, OffDebounce, 4'hF, 32'h3);
    for (int k = 0; k < 3; k++) step(12'h003, 0, 0, 12'h0, 4'h0, 32'h0);
    for (int k = 0; k < 2; k++) step(12'h001, 0, 0, 12'h0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) step(12'h003, 0, 0, 12'h0, 4'h0, 32'h0);
    step(12'h003, 1, 0, OffPend, 4'hF, 32'h0);
    check("d3_pend", rsp.rdata, 32'h3);

    step(12'h003, 1, 0, 12'h01C, 4'hF, 32'h0);
    check("err_flag", 32'(rsp.err), 32'd1);
    check("err_data", rsp.rdata, 32'hBADCAB1E);
    step(12'h003, 1, 0, OffEn, 4'hF, 32'h0);
    step(12'h003, 1, 0, OffMode, 4'hF, 32'h0);

    g = 12'h003;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      for (int ch = 0; ch < NC; ch++) if ($urandom_range(0, 3) == 0) g[ch] = ~g[ch];
      rq  = $urandom_range(0, 9) < 4;
      we  = 1'($urandom_range(0, 1));
      off = 12'($urandom_range(0, 9) * 4);
      be  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      wd  = (off == OffDebounce) ? 32'($urandom_range(0, 4)) : $urandom;
      step(g, rq, we, off, be, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
